counter_mod: RTL

- Parametrised successor to the team's 12-bit loadable counter.
- Adds a programmable modulus, an up/down direction input, a variable step, and a choice of wrap or saturate at the ends of the range.
- Adds a terminal-count pulse and a sticky overflow flag.
- Intended as the address/program counter that drives the ROM and sequences ALU test vectors in the lab datapath.

---
 rtl/counter_mod.sv | 84 ++++++++
 1 files changed

// File: rtl/counter_mod.sv
// Loadable modulo counter with up/down direction, variable step, wrap or
// saturate end mode, a registered terminal-count pulse and a sticky overflow flag.
module counter_mod #(
  parameter int WIDTH   = 12,
  parameter int MODULUS = 4096,
  parameter int STEP_W  = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              enabled,
  input  logic              load,
  input  logic [WIDTH-1:0]  ld,
  input  logic              up,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  y,
  output logic              tc,
  output logic              ovf
);

  // One extra bit so y+step and MODULUS itself (up to 2^WIDTH) are representable.
  localparam int                W1      = WIDTH + 1;
  localparam logic [W1-1:0]     MOD_EXT = W1'(MODULUS);
  localparam logic [W1-1:0]     MAX_EXT = W1'(MODULUS - 1);
  localparam logic [WIDTH-1:0]  MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] y_q, y_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [W1-1:0]    y_ext, step_ext, sum_ext;
  logic             evt;

  assign y_ext    = {1'b0, y_q};
  assign step_ext = W1'(step);
  assign sum_ext  = y_ext + step_ext;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    y_d  = y_q;
    tc_d = 1'b0;
    evt  = 1'b0;
    if (load) begin
      y_d = ({1'b0, ld} > MAX_EXT) ? MAX_VAL : ld;
    end else if (enabled && (step != '0)) begin
      if (up) begin
        if (sum_ext <= MAX_EXT) begin
          y_d = sum_ext[WIDTH-1:0];
        end else begin
          evt = 1'b1;
          y_d = sat ? MAX_VAL : WIDTH'(sum_ext - MOD_EXT);
        end
      end else begin
        if (step_ext <= y_ext) begin
          y_d = WIDTH'(y_ext - step_ext);
        end else begin
          evt = 1'b1;
          y_d = sat ? '0 : WIDTH'(y_ext + MOD_EXT - step_ext);
        end
      end
      tc_d = evt || (up ? (y_d == MAX_VAL) : (y_d == '0));
    end
    // A new event outranks a clear requested on the same edge.
    ovf_d = evt | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      y_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign y   = y_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule
